// File: rtl/gate_sweep_driver.sv
// Exhaustive stimulus generator and response checker for a combinational gate under test.
// Optional: define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module gate_sweep_driver #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int OP     = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [N_IN-1:0] LAST_VEC   = '1;
    localparam logic [N_IN:0]   ERR_MAX    = {1'b1, {N_IN{1'b0}}};
    localparam logic [7:0]      SETTLE_CNT = 8'(SETTLE);

    state_t            state_reg, state_next;
    logic [N_IN-1:0]   vec_reg, vec_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [N_IN:0]     err_reg, err_next;
    logic              fv_reg, fv_next;
    logic [N_IN-1:0]   ffv_reg, ffv_next;

    logic              expected;
    logic              mismatch;
    logic              stop_now;

    always_comb begin
        case (OP)
            1:       expected =  (|vec_reg);
            2:       expected =  (^vec_reg);
            3:       expected = ~(&vec_reg);
            4:       expected = ~(|vec_reg);
            5:       expected = ~(^vec_reg);
            default: expected =  (&vec_reg);
        endcase
    end

    assign mismatch = (dut_out != expected);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        vec_next   = vec_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        fv_next    = fv_reg;
        ffv_next   = ffv_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = APPLY;
                    vec_next   = '0;
                    cnt_next   = '0;
                    err_next   = '0;
                    fv_next    = 1'b0;
                    ffv_next   = '0;
                end
            end
            APPLY: begin
                if (cnt_reg == SETTLE_CNT) begin
                    if (mismatch) begin
                        if (err_reg != ERR_MAX)
                            err_next = err_reg + 1'b1;
                        if (!fv_reg) begin
                            fv_next  = 1'b1;
                            ffv_next = vec_reg;
                        end
                    end
                    // dut_in is left on the final (or failing) vector rather than wrapping
                    if (stop_now || (vec_reg == LAST_VEC)) begin
                        state_next = DONE;
                    end else begin
                        vec_next = vec_reg + 1'b1;
                        cnt_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            vec_reg   <= '0;
            cnt_reg   <= '0;
            err_reg   <= '0;
            fv_reg    <= 1'b0;
            ffv_reg   <= '0;
        end else begin
            state_reg <= state_next;
            vec_reg   <= vec_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            fv_reg    <= fv_next;
            ffv_reg   <= ffv_next;
        end
    end

    assign dut_in         = vec_reg;
    assign busy           = (state_reg == APPLY);
    assign done           = (state_reg == DONE);
    assign pass           = done && (err_reg == '0);
    assign err_count      = err_reg;
    assign fail_valid     = fv_reg;
    assign first_fail_vec = ffv_reg;

endmodule

// File: tb/tb_gate_sweep_driver.sv
// Directed bench for gate_sweep_driver: AND and OR checkers (SETTLE=1) plus an AND checker with SETTLE=0.
module tb_gate_sweep_driver;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    int   mode = 0;   // 0 AND gate, 1 const 0, 2 const 1, 3 NAND gate, 4 OR gate

    logic [1:0] a_in, o_in, s_in;
    logic       a_out, o_out, s_out;
    logic       a_busy, a_done, a_pass, a_fv;
    logic       o_busy, o_done, o_pass, o_fv;
    logic       s_busy, s_done, s_pass, s_fv;
    logic [2:0] a_err, o_err, s_err;
    logic [1:0] a_ffv, o_ffv, s_ffv;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic gate(input int m, input logic [1:0] v);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~(&v);
            4:       return |v;
            default: return &v;
        endcase
    endfunction

    assign a_out = gate(mode, a_in);
    assign o_out = gate(mode, o_in);
    assign s_out = gate(mode, s_in);

    gate_sweep_driver #(.N_IN(2), .SETTLE(1), .OP(0)) u_and (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(a_in), .dut_out(a_out),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
        .fail_valid(a_fv), .first_fail_vec(a_ffv));

    gate_sweep_driver #(.N_IN(2), .SETTLE(1), .OP(1)) u_or (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(o_in), .dut_out(o_out),
        .busy(o_busy), .done(o_done), .pass(o_pass), .err_count(o_err),
        .fail_valid(o_fv), .first_fail_vec(o_ffv));

    gate_sweep_driver #(.N_IN(2), .SETTLE(0), .OP(0)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(s_in), .dut_out(s_out),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .fail_valid(s_fv), .first_fail_vec(s_ffv));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " dut_in"}, 32'(a_in), 0);
        chk({tag, " busy"}, 32'(a_busy), 0);
        chk({tag, " done"}, 32'(a_done), 0);
        chk({tag, " pass"}, 32'(a_pass), 0);
        chk({tag, " err"}, 32'(a_err), 0);
        chk({tag, " fv"}, 32'(a_fv), 0);
        chk({tag, " ffv"}, 32'(a_ffv), 0);
    endtask

    // Leaves the bench at the negedge right after the start-accepting edge.
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    typedef struct {
        int mode;
        int and_err; int and_fv; int and_ffv;
        int or_err;  int or_fv;  int or_ffv;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int e_err, e_din;

        tbl[0] = '{0, 0, 0, 0, 2, 1, 1};
        tbl[1] = '{1, 1, 1, 3, 3, 1, 1};
        tbl[2] = '{2, 3, 1, 0, 1, 1, 0};
        tbl[3] = '{3, 4, 1, 0, 2, 1, 0};
        tbl[4] = '{4, 2, 1, 1, 0, 0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk_reset("reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle busy", 32'(a_busy), 0);

        // Ideal AND gate: vector pacing and done timing
        mode = 0;
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("t1 and dut_in n%0d", k), 32'(a_in), 32'((k - 1) / 2));
            chk($sformatf("t1 and busy n%0d", k), 32'(a_busy), 1);
            chk($sformatf("t1 and done n%0d", k), 32'(a_done), 0);
            if (k <= 4)
                chk($sformatf("t1 s0 dut_in n%0d", k), 32'(s_in), 32'(k - 1));
            if (k == 5)
                chk("t1 s0 done", 32'(s_done), 1);
            @(negedge clk);
        end
        chk("t1 done", 32'(a_done), 1);
        chk("t1 busy", 32'(a_busy), 0);
        chk("t1 pass", 32'(a_pass), 1);
        chk("t1 err", 32'(a_err), 0);
        chk("t1 fv", 32'(a_fv), 0);
        chk("t1 dut_in held", 32'(a_in), 3);
        $display("[TB] sweep ideal AND: done=%0d pass=%0d err=%0d", a_done, a_pass, a_err);

        // Table of full sweeps with different gate behaviours
        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            pulse_start();
            repeat (8) @(negedge clk);
            e_err = (STOP && tbl[i].and_err > 0) ? 1 : tbl[i].and_err;
            e_din = (STOP && tbl[i].and_fv != 0) ? tbl[i].and_ffv : 3;
            chk($sformatf("tbl%0d and done", i), 32'(a_done), 1);
            chk($sformatf("tbl%0d and busy", i), 32'(a_busy), 0);
            chk($sformatf("tbl%0d and err", i), 32'(a_err), 32'(e_err));
            chk($sformatf("tbl%0d and fv", i), 32'(a_fv), 32'(tbl[i].and_fv));
            chk($sformatf("tbl%0d and pass", i), 32'(a_pass), 32'(tbl[i].and_err == 0));
            chk($sformatf("tbl%0d and dut_in", i), 32'(a_in), 32'(e_din));
            if (tbl[i].and_fv != 0)
                chk($sformatf("tbl%0d and ffv", i), 32'(a_ffv), 32'(tbl[i].and_ffv));
            e_err = (STOP && tbl[i].or_err > 0) ? 1 : tbl[i].or_err;
            chk($sformatf("tbl%0d or err", i), 32'(o_err), 32'(e_err));
            chk($sformatf("tbl%0d or fv", i), 32'(o_fv), 32'(tbl[i].or_fv));
            chk($sformatf("tbl%0d or pass", i), 32'(o_pass), 32'(tbl[i].or_err == 0));
            if (tbl[i].or_fv != 0)
                chk($sformatf("tbl%0d or ffv", i), 32'(o_ffv), 32'(tbl[i].or_ffv));
            $display("[TB] vec %0d mode %0d: and err=%0d ffv=%0d, or err=%0d ffv=%0d",
                     i, mode, a_err, a_ffv, o_err, o_ffv);
        end

        // SETTLE=0 checker against a stuck-at-1 output
        mode = 2;
        pulse_start();
        @(negedge clk);
        if (STOP) begin
            chk("t6 done", 32'(s_done), 1);
            chk("t6 dut_in", 32'(s_in), 0);
        end else begin
            chk("t6 busy", 32'(s_busy), 1);
            chk("t6 dut_in", 32'(s_in), 1);
        end
        chk("t6 err", 32'(s_err), 1);
        chk("t6 fv", 32'(s_fv), 1);
        chk("t6 ffv", 32'(s_ffv), 0);
        repeat (3) @(negedge clk);
        chk("t6 final done", 32'(s_done), 1);
        chk("t6 final err", 32'(s_err), STOP ? 1 : 3);
        $display("[TB] sweep SETTLE=0 stuck-1: done=%0d err=%0d", s_done, s_err);

        // start held high from reset release: back-to-back sweeps
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        chk_reset("t4 reset");
        mode  = 1;
        rst_n = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("t4 busy n%0d", k), 32'(a_busy), 1);
        end
        @(negedge clk);
        chk("t4 done1", 32'(a_done), 1);
        chk("t4 err1", 32'(a_err), 1);
        chk("t4 ffv1", 32'(a_ffv), 3);
        mode = 0;
        @(negedge clk);
        chk("t4 restart done", 32'(a_done), 0);
        chk("t4 restart busy", 32'(a_busy), 1);
        chk("t4 restart err", 32'(a_err), 0);
        chk("t4 restart fv", 32'(a_fv), 0);
        repeat (8) @(negedge clk);
        chk("t4 done2", 32'(a_done), 1);
        chk("t4 pass2", 32'(a_pass), 1);
        @(negedge clk);
        chk("t4 done pulse", 32'(a_done), 0);
        @(negedge clk) start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4 done3", 32'(a_done), 1);
        $display("[TB] back-to-back sweeps: done=%0d err=%0d", a_done, a_err);

        // Asynchronous reset mid-sweep during vector 01
        mode = 2;
        pulse_start();
        repeat (2) @(negedge clk);
        chk("t5 err before", 32'(a_err), 1);
        if (!STOP)
            chk("t5 dut_in before", 32'(a_in), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("t5 async");
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5 idle busy", 32'(a_busy), 0);
        chk("t5 idle done", 32'(a_done), 0);
        chk("t5 idle dut_in", 32'(a_in), 0);
        chk("t5 idle err", 32'(a_err), 0);
        $display("[TB] reset mid-sweep: busy=%0d done=%0d dut_in=%0d", a_busy, a_done, a_in);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gate_sweep_driver.md
Name: gate_sweep_driver

Overview:
Self-contained stimulus generator and response checker for a combinational gate under test in the logic-gate lab set. It sits directly upstream and downstream of the gate. It drives every input combination in binary order, holds each one for a programmable settle time, samples the gate output, and compares it against the expected truth-table value. It reports pass/fail, a mismatch count and the first failing vector, so gate modules are checked in hardware rather than by eye on waveforms.

Parameters:
N_IN, 2, number of gate inputs (1..8); the sweep covers 2^N_IN vectors.
SETTLE, 1, extra cycles each vector is held before sampling (0..255).
OP, 0, expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; any other value is treated as AND.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  level-sampled request to begin a sweep.
dut_in  output  N_IN  input vector to the gate under test; bit 0 is the first gate input.
dut_out  input  1  gate output, sampled by this block.
busy  output  1  high while a sweep is in progress.
done  output  1  high once a sweep has finished; sticky until the next accepted start.
pass  output  1  equals done AND (err_count == 0).
err_count  output  N_IN+1  number of mismatching vectors, saturating at 2^N_IN.
fail_valid  output  1  high once any mismatch has been captured in the current sweep.
first_fail_vec  output  N_IN  vector of the first mismatch; meaningful only while fail_valid is high.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, named rst_n. Assertion clears all state immediately, regardless of clk. Deassertion is synchronised by the system.
- Reset values: state IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0; internal vector register=0, hold counter=0.
- FSM states: IDLE, APPLY, DONE.
- IDLE, or DONE, with start=1 at a rising edge:
  - go to APPLY;
  - vector=0, dut_in=0, hold counter=0;
  - clear err_count, fail_valid, first_fail_vec and done.
  - busy=1 from that edge.
- APPLY:
  - dut_in holds the current vector for exactly SETTLE+1 cycles.
  - The hold counter increments each edge. On the edge where counter==SETTLE, dut_out is compared with expected(OP, vector).
  - Expected value: AND = &vector; OR = |vector; XOR = ^vector; NAND, NOR and XNOR are their complements.
  - On mismatch: err_count increments, saturating. If fail_valid=0, first_fail_vec=vector and fail_valid=1 on the same edge.
  - Same compare edge, vector < 2^N_IN-1: vector and dut_in increment, counter resets to 0.
  - Same compare edge, vector == 2^N_IN-1: go to DONE; busy=0, done=1. dut_in keeps the last vector; it does not wrap to 0.
- Sweep length: exactly 2^N_IN*(SETTLE+1) cycles from the start-accepting edge to the edge that sets done. With defaults this is 8.
- start while in APPLY is ignored, including when held high continuously.
- start held high in DONE: a new sweep begins on the next edge. Consecutive sweeps therefore run back-to-back, with done high for one cycle between them.
- rst_n low mid-sweep: immediate return to reset values. No partial result is reported.
- N_IN=1: vectors 0,1 only; err_count is 2 bits.
- dut_out is assumed stable by the sample edge. The block adds no synchroniser.

Optional Feature:
Macro GATE_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the sweep. On that compare edge, go to DONE with err_count=1, fail_valid=1 and first_fail_vec set; dut_in holds the failing vector.
- Undefined: the sweep always covers all 2^N_IN vectors, as described above.

Test Plan:
1. Defaults with an ideal AND gate (dut_out=&dut_in); reset, then start pulse for 1 cycle -> dut_in shows 00,01,10,11, each held 2 cycles; done=1 at the 8th edge after start; pass=1, err_count=0, fail_valid=0, busy low again.
2. dut_out tied to 0 -> after 8 cycles err_count=1, fail_valid=1, first_fail_vec=2'b11, pass=0.
3. dut_out tied to 1 -> err_count=3, first_fail_vec=2'b00; OP=1 with the same stuck-at-1 gives err_count=1, first_fail_vec=2'b00.
4. start held high from reset release for 20 cycles, ideal AND gate -> start is ignored while busy; done pulses high for 1 cycle at edges 8 and 17; err_count is cleared at each restart.
5. rst_n driven low mid-cycle during vector 01 -> all outputs are 0 immediately, before the next clk edge; after release the block stays IDLE until start.
6. GATE_SWEEP_STOP_ON_FAIL_EN defined, dut_out tied to 1, SETTLE=0 -> done=1 at the 1st edge after start; err_count=1, dut_in=2'b00, first_fail_vec=2'b00.
